arena_life_engine: RTL and testbench
====================================

ARENA_LIFE_ENGINE -- requirements
Module: arena_life_engine

Interface
REQ-001 Parameter ARENA_WIDTH, default 10, cells per row; legal range 3..64.
REQ-002 Parameter ARENA_HEIGHT, default 10, rows in arena; legal range 3..64.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 row_select  input  8  display read row index.
REQ-006 column_select  input  8  display read column index.
REQ-007 cell_value  output  1  state of the addressed cell in the front bank.
REQ-008 frame_start  input  1  one-cycle pulse at start of vertical blanking.
REQ-009 step_req  input  1  request to compute one generation.
REQ-010 step_busy  output  1  generation in progress or awaiting swap.
REQ-011 step_done  output  1  one-cycle pulse when the new generation becomes visible.
REQ-012 load_en  input  1  seed write strobe.
REQ-013 load_row  input  8  row index for seed write.
REQ-014 load_data  input  ARENA_WIDTH  seed row, bit i = column i.
REQ-015 gen_count  output  16  generations completed.

Function
REQ-016 Two cell banks, each ARENA_WIDTH x ARENA_HEIGHT bits; front_sel register selects the displayed (front) bank.
REQ-017 cell_value: combinational from front bank, zero read latency; 0 when row_select >= ARENA_HEIGHT or column_select >= ARENA_WIDTH.
REQ-018 FSM states: IDLE, CALC, WAIT_FRAME.
REQ-019 IDLE: load_en with load_row < ARENA_HEIGHT writes load_data into front bank row at next edge; load_row out of range ignored.
REQ-020 IDLE: step_req with load_en low -> CALC at next edge, row counter = 0.
REQ-021 IDLE: step_req and load_en together -> load performed, step_req dropped.
REQ-022 CALC: each cycle computes the full next-state row for row counter r from front rows r-1, r, r+1 and writes it to back bank row r; after row ARENA_HEIGHT-1 -> WAIT_FRAME; CALC lasts exactly ARENA_HEIGHT cycles.
REQ-023 Next-state rule: live cell with 2 or 3 live neighbours stays live; dead cell with exactly 3 becomes live; else dead; neighbour count 4 bits.
REQ-024 WAIT_FRAME: on frame_start toggle front_sel, increment gen_count (wraps 0xFFFF -> 0), pulse step_done next cycle, return to IDLE.
REQ-025 frame_start sampled only in WAIT_FRAME; a pulse during IDLE or CALC (including final CALC cycle) is ignored.
REQ-026 step_busy = 1 in CALC and WAIT_FRAME, else 0; step_req and load_en ignored while busy.
REQ-027 Front bank never written outside IDLE; displayed image changes only at swap or IDLE load.

Reset
REQ-028 reset_n low asynchronously: state IDLE, both banks all 0, front_sel 0, row counter 0, gen_count 0, step_busy 0, step_done 0.
REQ-029 Reset mid-CALC or mid-WAIT_FRAME aborts the generation; no swap, no step_done.
REQ-030 Logic leaves reset on first clk edge after reset_n high.

Configuration
REQ-031 Macro ARENA_LIFE_WRAP_EN defined: toroidal arena, neighbours wrap (row -1 = ARENA_HEIGHT-1, column -1 = ARENA_WIDTH-1, and vice versa).
REQ-032 ARENA_LIFE_WRAP_EN undefined: cells outside arena count as dead.

Verification
REQ-033 Blinker: load row 4 = cols 3..5 live, step_req, frame_start after CALC -> cols 4 rows 3..5 live, gen_count = 1, step_done one pulse.
REQ-034 Latency: step_req at cycle N, frame_start held high -> step_busy N+1..N+ARENA_HEIGHT+1, front_sel toggles at N+ARENA_HEIGHT+1, step_done at N+ARENA_HEIGHT+2.
REQ-035 Glider at top-left, 40 steps on 10x10: with ARENA_LIFE_WRAP_EN glider shape intact, shifted (+10,+10) mod 10 = original position; without it, collapses to block or empty.
REQ-036 Out-of-range read: row_select = 10 or column_select = 200 -> cell_value 0 regardless of bank contents.
REQ-037 step_req and load_en pulsed during CALC -> no effect on banks or gen_count; frame_start during CALC -> no swap until next frame_start in WAIT_FRAME.
REQ-038 reset_n low at CALC row 5 -> banks cleared, gen_count 0, step_busy 0, no step_done.

Source files
------------

// File: rtl/arena_life_engine.sv
// Double-buffered Game of Life engine: back bank is computed one row per cycle, swapped at frame start.
// Optional macro ARENA_LIFE_WRAP_EN selects a toroidal arena; default treats out-of-arena cells as dead.
module arena_life_engine #(
  parameter int unsigned ARENA_WIDTH  = 10,
  parameter int unsigned ARENA_HEIGHT = 10
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [7:0]             row_select,
  input  logic [7:0]             column_select,
  output logic                   cell_value,
  input  logic                   frame_start,
  input  logic                   step_req,
  output logic                   step_busy,
  output logic                   step_done,
  input  logic                   load_en,
  input  logic [7:0]             load_row,
  input  logic [ARENA_WIDTH-1:0] load_data,
  output logic [15:0]            gen_count
);

  localparam int unsigned RW = $clog2(ARENA_HEIGHT);
  localparam int unsigned CW = $clog2(ARENA_WIDTH);
  localparam logic [RW-1:0] LAST_ROW = RW'(ARENA_HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, CALC, WAIT_FRAME} state_t;

  state_t                 state_q, state_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   front_sel_q, front_sel_d;
  logic [15:0]            gen_q, gen_d;
  logic                   done_q, done_d;
  logic                   busy_q;
  logic                   load_we, calc_we;

  logic [ARENA_WIDTH-1:0] bank0_q [ARENA_HEIGHT];
  logic [ARENA_WIDTH-1:0] bank1_q [ARENA_HEIGHT];
  logic [ARENA_WIDTH-1:0] front_row [ARENA_HEIGHT];
  logic [ARENA_WIDTH-1:0] up_row, mid_row, dn_row, next_row;
  logic [ARENA_WIDTH+1:0] up_x, mid_x, dn_x;
  logic [3:0]             cnt;

  // Pad a row with the column -1 (bit 0) and column W (bit W+1) neighbours.
  function automatic logic [ARENA_WIDTH+1:0] extend(input logic [ARENA_WIDTH-1:0] r);
`ifdef ARENA_LIFE_WRAP_EN
    return {r[0], r, r[ARENA_WIDTH-1]};
`else
    return {1'b0, r, 1'b0};
`endif
  endfunction

  always_comb begin
    for (int i = 0; i < int'(ARENA_HEIGHT); i++) begin
      front_row[i] = front_sel_q ? bank1_q[i] : bank0_q[i];
    end
  end

  // Display read port, zero latency.
  always_comb begin
    cell_value = 1'b0;
    if ((row_select < 8'(ARENA_HEIGHT)) && (column_select < 8'(ARENA_WIDTH))) begin
      cell_value = front_row[row_select[RW-1:0]][column_select[CW-1:0]];
    end
  end

  // Neighbour rows of the row being computed.
  always_comb begin
    mid_row = front_row[row_q];
    up_row  = '0;
    dn_row  = '0;
    if (row_q != '0) up_row = front_row[row_q - RW'(1)];
`ifdef ARENA_LIFE_WRAP_EN
    else up_row = front_row[LAST_ROW];
`endif
    if (row_q != LAST_ROW) dn_row = front_row[row_q + RW'(1)];
`ifdef ARENA_LIFE_WRAP_EN
    else dn_row = front_row[0];
`endif
  end

  always_comb begin
    up_x     = extend(up_row);
    mid_x    = extend(mid_row);
    dn_x     = extend(dn_row);
    cnt      = '0;
    next_row = '0;
    for (int c = 0; c < int'(ARENA_WIDTH); c++) begin
      cnt = 4'(up_x[c]) + 4'(up_x[c+1]) + 4'(up_x[c+2]) +
            4'(mid_x[c]) + 4'(mid_x[c+2]) +
            4'(dn_x[c]) + 4'(dn_x[c+1]) + 4'(dn_x[c+2]);
      next_row[c] = (cnt == 4'd3) || (mid_x[c+1] && (cnt == 4'd2));
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    front_sel_d = front_sel_q;
    gen_d       = gen_q;
    done_d      = 1'b0;
    load_we     = 1'b0;
    calc_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          load_we = (load_row < 8'(ARENA_HEIGHT));
        end else if (step_req) begin
          state_d = CALC;
          row_d   = '0;
        end
      end
      CALC: begin
        calc_we = 1'b1;
        if (row_q == LAST_ROW) begin
          state_d = WAIT_FRAME;
          row_d   = '0;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      WAIT_FRAME: begin
        if (frame_start) begin
          front_sel_d = ~front_sel_q;
          gen_d       = gen_q + 16'd1;
          done_d      = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      front_sel_q <= 1'b0;
      gen_q       <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      front_sel_q <= front_sel_d;
      gen_q       <= gen_d;
      done_q      <= done_d;
      busy_q      <= (state_d != IDLE);
    end
  end

  // Seed loads go to the front bank; computed rows go to the back bank.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(ARENA_HEIGHT); i++) begin
        bank0_q[i] <= '0;
        bank1_q[i] <= '0;
      end
    end else begin
      if (load_we) begin
        if (front_sel_q) bank1_q[load_row[RW-1:0]] <= load_data;
        else             bank0_q[load_row[RW-1:0]] <= load_data;
      end
      if (calc_we) begin
        if (front_sel_q) bank0_q[row_q] <= next_row;
        else             bank1_q[row_q] <= next_row;
      end
    end
  end

  assign step_busy = busy_q;
  assign step_done = done_q;
  assign gen_count = gen_q;

endmodule

// File: tb/tb_arena_life_engine.sv
// Randomized bench for arena_life_engine against a generation-level Game of Life model.
module tb_arena_life_engine;
  localparam int W = 10;
  localparam int H = 10;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [7:0]   row_select = '0;
  logic [7:0]   column_select = '0;
  logic         cell_value;
  logic         frame_start = 1'b0;
  logic         step_req = 1'b0;
  logic         step_busy;
  logic         step_done;
  logic         load_en = 1'b0;
  logic [7:0]   load_row = '0;
  logic [W-1:0] load_data = '0;
  logic [15:0]  gen_count;

  always #5 clk = ~clk;

  arena_life_engine #(.ARENA_WIDTH(W), .ARENA_HEIGHT(H)) dut (
    .clk(clk), .reset_n(reset_n), .row_select(row_select), .column_select(column_select),
    .cell_value(cell_value), .frame_start(frame_start), .step_req(step_req),
    .step_busy(step_busy), .step_done(step_done), .load_en(load_en), .load_row(load_row),
    .load_data(load_data), .gen_count(gen_count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: whole-arena generations; mode 0 idle, 1 computing, 2 waiting for frame.
  bit m_front [H][W];
  bit m_nxt   [H][W];
  int m_mode, m_left, m_gen;
  bit m_done;

  function automatic bit life_cell(input int r, input int c);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        int rr = r + dr;
        int cc = c + dc;
        if (dr == 0 && dc == 0) continue;
`ifdef ARENA_LIFE_WRAP_EN
        rr = (rr + H) % H;
        cc = (cc + W) % W;
`else
        if (rr < 0 || rr >= H || cc < 0 || cc >= W) continue;
`endif
        n += int'(m_front[rr][cc]);
      end
    end
    return (n == 3) || (m_front[r][c] && n == 2);
  endfunction

  function automatic bit m_cell(input int rs, input int cs);
    if (rs >= H || cs >= W) return 1'b0;
    return m_front[rs][cs];
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_mode <= 0; m_left <= 0; m_gen <= 0; m_done <= 1'b0;
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          m_front[r][c] <= 1'b0;
          m_nxt[r][c]   <= 1'b0;
        end
    end else begin
      m_done <= 1'b0;
      case (m_mode)
        0: begin
          if (load_en) begin
            if (int'(load_row) < H)
              for (int c = 0; c < W; c++) m_front[int'(load_row)][c] <= load_data[c];
          end else if (step_req) begin
            m_mode <= 1;
            m_left <= H;
            for (int r = 0; r < H; r++)
              for (int c = 0; c < W; c++) m_nxt[r][c] <= life_cell(r, c);
          end
        end
        1: begin
          m_left <= m_left - 1;
          if (m_left == 1) m_mode <= 2;
        end
        default: begin
          if (frame_start) begin
            for (int r = 0; r < H; r++)
              for (int c = 0; c < W; c++) m_front[r][c] <= m_nxt[r][c];
            m_gen  <= (m_gen + 1) & 32'hFFFF;
            m_done <= 1'b1;
            m_mode <= 0;
          end
        end
      endcase
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    chk("busy", 32'(step_busy), 32'(m_mode != 0));
    chk("done", 32'(step_done), 32'(m_done));
    chk("gen", 32'(gen_count), 32'(m_gen));
    chk("cell", 32'(cell_value), 32'(m_cell(int'(row_select), int'(column_select))));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int r, input logic [W-1:0] d);
    load_en = 1'b1; load_row = 8'(r); load_data = d;
    cyc();
    load_en = 1'b0;
  endtask

  task automatic sweep();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        row_select = 8'(r); column_select = 8'(c);
        cyc();
      end
  endtask

  task automatic rand_sel();
    row_select    = ($urandom_range(0, 7) == 0) ? 8'd200 : 8'($urandom_range(0, H + 2));
    column_select = ($urandom_range(0, 7) == 0) ? 8'd200 : 8'($urandom_range(0, W + 2));
  endtask

  task automatic do_step();
    bit got = 1'b0;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    for (int i = 0; i < H + 60; i++) begin
      frame_start = ($urandom_range(0, 3) == 0);
      rand_sel();
      cyc();
      if (step_done) begin
        got = 1'b1;
        break;
      end
    end
    frame_start = 1'b0;
    chk("step_done_seen", 32'(got), 32'd1);
  endtask

  int busy_n, done_n, done_at, last_busy, g0, live, mism;
  bit ok;
  logic [W-1:0] glider [3];

  initial begin
    glider[0] = 10'b0000000010;
    glider[1] = 10'b0000000100;
    glider[2] = 10'b0000000111;

    repeat (3) cyc();
    chk("rst_busy", 32'(step_busy), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_gen", 32'(gen_count), 32'd0);
    reset_n = 1'b1;
    cyc();

    // Blinker
    load(4, 10'b0000111000);
    do_step();
    chk("blk_m_r3", 32'(m_front[3][4]), 32'd1);
    chk("blk_m_r4", 32'(m_front[4][4]), 32'd1);
    chk("blk_m_r5", 32'(m_front[5][4]), 32'd1);
    chk("blk_m_c3", 32'(m_front[4][3]), 32'd0);
    chk("blk_m_c5", 32'(m_front[4][5]), 32'd0);
    chk("blk_gen", 32'(gen_count), 32'd1);
    row_select = 8'd3; column_select = 8'd4; #1;
    chk("blk_dut_r3c4", 32'(cell_value), 32'd1);
    row_select = 8'd4; column_select = 8'd3; #1;
    chk("blk_dut_r4c3", 32'(cell_value), 32'd0);
    row_select = 8'd10; column_select = 8'd4; #1;
    chk("oor_row10", 32'(cell_value), 32'd0);
    row_select = 8'd4; column_select = 8'd200; #1;
    chk("oor_col200", 32'(cell_value), 32'd0);
    sweep();

    // Latency with frame_start held high
    for (int r = 0; r < H; r++) load(r, W'($urandom));
    step_req = 1'b1; frame_start = 1'b1;
    cyc();
    step_req = 1'b0;
    busy_n = 0; done_n = 0; done_at = 0; last_busy = 0;
    for (int i = 1; i <= H + 4; i++) begin
      if (step_busy) begin busy_n++; last_busy = i; end
      if (step_done) begin done_n++; done_at = i; end
      cyc();
    end
    frame_start = 1'b0;
    chk("lat_busy_cnt", 32'(busy_n), 32'(H + 1));
    chk("lat_busy_last", 32'(last_busy), 32'(H + 1));
    chk("lat_done_at", 32'(done_at), 32'(H + 2));
    chk("lat_done_cnt", 32'(done_n), 32'd1);
    sweep();

    // Inputs pulsed during CALC are ignored, including frame_start on the last row
    g0 = int'(gen_count);
    step_req = 1'b1;
    cyc();
    for (int i = 1; i <= H; i++) begin
      step_req = (i % 2 == 0);
      load_en = (i % 3 == 0); load_row = 8'($urandom_range(0, H - 1)); load_data = W'($urandom);
      frame_start = 1'b1;
      rand_sel();
      cyc();
    end
    step_req = 1'b0; load_en = 1'b0; frame_start = 1'b0;
    repeat (3) cyc();
    chk("calc_wait_busy", 32'(step_busy), 32'd1);
    chk("calc_wait_gen", 32'(gen_count), 32'(g0));
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
    cyc();
    chk("calc_swap_gen", 32'(gen_count), 32'(g0 + 1));
    sweep();

    // Reset at CALC row 5
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    repeat (5) cyc();
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy", 32'(step_busy), 32'd0);
    chk("rstmid_gen", 32'(gen_count), 32'd0);
    chk("rstmid_done", 32'(step_done), 32'd0);
    repeat (2) cyc();
    reset_n = 1'b1;
    frame_start = 1'b1;
    repeat (3) cyc();
    frame_start = 1'b0;
    sweep();

    // Glider, 40 generations
    for (int r = 0; r < 3; r++) load(r, glider[r]);
    repeat (40) do_step();
    chk("glider_gen", 32'(gen_count), 32'd40);
    sweep();
    live = 0; mism = 0; ok = 1'b0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        live += int'(m_front[r][c]);
        if (m_front[r][c] != ((r < 3) ? glider[r][c] : 1'b0)) mism++;
      end
`ifdef ARENA_LIFE_WRAP_EN
    chk("glider_wrap", 32'(mism), 32'd0);
`else
    if (live == 0) ok = 1'b1;
    else if (live == 4) begin
      for (int r = 0; r < H - 1; r++)
        for (int c = 0; c < W - 1; c++)
          if (m_front[r][c] && m_front[r][c+1] && m_front[r+1][c] && m_front[r+1][c+1]) ok = 1'b1;
    end
    chk("glider_block", 32'(ok), 32'd1);
`endif

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      load_en     = ($urandom_range(0, 7) == 0);
      load_row    = 8'($urandom_range(0, H + 2));
      load_data   = W'($urandom);
      step_req    = ($urandom_range(0, 5) == 0);
      frame_start = ($urandom_range(0, 3) == 0);
      rand_sel();
      if ($urandom_range(0, 999) == 0) reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
    end
    load_en = 1'b0; step_req = 1'b0; frame_start = 1'b0;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
